mipse_cpu: RTL and testbench
============================

# mipse_cpu

Single-cycle 32-bit MIPS-subset processor core. It fetches one instruction per clock from an external combinational instruction memory and reads data from an external data memory. Stores go to that memory through a synchronous write strobe. It is the compute element of the mipse system; imem and dmem are separate blocks word-addressed by `pc[17:2]` and `aluresult[17:2]`.

## Interface
- `DATA_W`, default 32: data, address and instruction width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-high. The port keeps its `_n` name, but `1` means reset asserted.
- `instr` in 32: instruction word at `pc`, combinational from imem.
- `readdata` in 32: data word at `aluresult`, combinational from dmem.
- `pc` out 32: current program counter, byte address.
- `aluresult` out 32: ALU output; also the data memory byte address.
- `writedata` out 32: store data, the rt register value.
- `memwrite` out 1: store strobe. dmem writes `writedata` on the rising edge while it is high.

## Operation
- Register file: 32×32. Instance `rfile_1`, array `rf[0:31]`.
  - Two combinational read ports, one write port written on the clock edge.
  - Writes to `$0` are discarded; `rf[0]` always reads 0.
- R-type instructions (opcode 0x00), by funct:
  - add 0x20, sub 0x22, and 0x24, or 0x25: two's-complement or bitwise on rs and rt.
  - slt 0x2a: signed compare; result is 1 or 0.
  - sll 0x00 and srl 0x02: shift rt by shamt.
  - jr 0x08: pc ← rs.
  - Result written to rd.
- I-type ALU instructions, result written to rt:
  - addi 0x08 and slti 0x0a use a sign-extended immediate.
  - andi 0x0c and ori 0x0d use a zero-extended immediate.
  - lui 0x0f: imm<<16.
- Memory instructions (address = rs + sext(imm), driven on `aluresult`):
  - lw 0x23: rt ← `readdata`.
  - sw 0x2b: `memwrite`=1 and `writedata`=rt.
  - lb 0x20: rt ← sext(byte), where byte = `readdata[8*aluresult[1:0] +: 8]` (little-endian lane select).
- Branches and jumps:
  - beq 0x04 and bne 0x05: target = pc+4+(sext(imm)<<2); taken when rs==rt (beq) or rs!=rt (bne).
  - j 0x02: pc ← {pc+4[31:28], target26, 2'b00}.
  - jal 0x03: same target as j, and $31 ← pc+4.
- Otherwise pc ← pc+4; arithmetic wraps modulo 2^32 and there are no overflow exceptions.
- Undefined opcode or funct: NOP, meaning no register write, `memwrite`=0 and pc+4.
- Internal signals `lb_op` (high while an lb executes) and `result` (the writeback value) are named exactly so, for bench probing.
- Software halt convention: a store with `aluresult`==0x7fff. The core treats it as a normal sw; the system detects it.

## Timing
- Single-cycle, CPI 1. Decode, ALU, memory read and writeback result are combinational within the cycle. pc, register write and the dmem write commit on the next rising edge.
- Reset asserted, effective immediately and regardless of `clk`:
  - pc=0 and all registers cleared to 0.
  - `memwrite` forced to 0.
  - `aluresult` and `writedata` are don't-care.
- Reset mid-operation: the in-flight instruction is abandoned with no register or memory write.
- After release, the first rising edge executes the instruction at address 0.
- Register read and write of the same register in one cycle: the read returns the old value. The new value is visible in the next cycle.
- A branch or jump executes with no delay slot.

## Configuration
- `MIPSE_LB_EN` defined: lb (opcode 0x20) is decoded as specified and `lb_op` is functional.
- `MIPSE_LB_EN` undefined: opcode 0x20 is a NOP and `lb_op` is tied to 0.

## Structure
- Shared package `mipse_pkg` holds:
  - `DATA_W`.
  - Opcode and funct constants.
  - ALU-control enum (ADD, SUB, AND, OR, SLT, SLL, SRL, LUI).
  - `ENABLE`/`DISABLE` level constants.
- One sub-module, `mipse_rfile`, instantiated as `rfile_1`. It holds the register array `rf` with 2 read ports and 1 write port, plus async clear.
- Decoder, ALU, next-pc logic and load alignment stay in the top module.

## Test plan
- Reset: hold `rst_n`=1 → `pc`=0, `memwrite`=0, `rf[1..31]`=0. Release → the first edge moves pc to 4.
- ALU: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; lui $5,0x1234; ori $5,$5,0x5678 → $3=2, $4=1, $5=0x12345678.
- Memory:
  - addi $6,$0,0x400; sw $1,0($6) → `memwrite`=1, `aluresult`=0x400, `writedata`=5 in that cycle.
  - lw $7,0($6) with `readdata`=5 → $7=5.
- lb: `aluresult`=0x401 and `readdata`=0x000080ff → rt=0xffffff80. With `MIPSE_LB_EN` undefined, rt is unchanged.
- Control flow:
  - beq $1,$1,+2 at pc 0x10 → pc 0x1c.
  - bne $1,$1 → pc+4.
  - jal 0x40 at pc 0x20 → pc=0x100 and $31=0x24.
  - jr $31 → pc=0x24.
- Halt and reset mid-run:
  - addi $8,$0,0x7fff; sw $1,0($8) → `memwrite`=1 with `aluresult`=0x7fff.
  - Assert `rst_n` between edges → pc=0 immediately and no write commits.

Source files
------------

// File: rtl/mipse_pkg.sv
// mipse_pkg: shared width, opcode/funct constants, ALU-control enum and level constants
package mipse_pkg;
  localparam int DATA_W = 32;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c,
                         OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LB = 6'h20, OP_LW = 6'h23,
                         OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                         F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2a;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI} alu_t;
endpackage

// File: rtl/mipse_if.sv
// mipse_if: core <-> imem/dmem bus; master = core (instr/readdata in; pc/aluresult/writedata/memwrite out)
interface mipse_if;
  import mipse_pkg::*;
  logic [DATA_W-1:0] instr, readdata, pc, aluresult, writedata;
  logic memwrite;
  modport master(input instr, readdata, output pc, aluresult, writedata, memwrite);
  modport slave(output instr, readdata, input pc, aluresult, writedata, memwrite);
endinterface

// File: rtl/mipse_rfile.sv
// mipse_rfile: 32x32 register file, 2 async read ports, 1 write port; ports clk, rst_n (active-high async clear), we/wa/wd, ra1/ra2 -> rd1/rd2
module mipse_rfile
  import mipse_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] rf [0:31];
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n)
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (we && wa != 5'd0)
      rf[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : rf[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : rf[ra2];
endmodule

// File: rtl/mipse_cpu.sv
// mipse_cpu: single-cycle MIPS-subset core; ports clk, rst_n (active-high async), bus (mipse_if.master); `MIPSE_LB_EN enables lb
module mipse_cpu
  import mipse_pkg::*;
(
  input logic      clk,
  input logic      rst_n,
  mipse_if.master  bus
);
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt, wa;
  logic [15:0] imm;
  logic [DATA_W-1:0] a, b, rt_val, ext, pc4, result, lbv, pc_next;
  logic regwrite, regdst, alusrc, zimm, memwr, ld, branch, bne, jump, link, jr, taken, lb_op;
  alu_t alu;
  assign {op, rs, rt, rd, shamt, funct} = bus.instr;
  assign imm = bus.instr[15:0];
  assign ext = zimm ? {16'h0, imm} : {{16{imm[15]}}, imm};
`ifdef MIPSE_LB_EN
  assign lb_op = op == OP_LB;
`else
  assign lb_op = DISABLE;
`endif
  always_comb begin
    regwrite = DISABLE; regdst = 1'b0; alusrc = 1'b0; zimm = 1'b0; alu = ALU_ADD;
    memwr = DISABLE; ld = 1'b0; branch = 1'b0; bne = 1'b0; jump = 1'b0; link = 1'b0; jr = 1'b0;
    case (op)
      OP_R: begin
        regdst = 1'b1;
        case (funct)
          F_ADD: regwrite = ENABLE;
          F_SUB: begin regwrite = ENABLE; alu = ALU_SUB; end
          F_AND: begin regwrite = ENABLE; alu = ALU_AND; end
          F_OR:  begin regwrite = ENABLE; alu = ALU_OR; end
          F_SLT: begin regwrite = ENABLE; alu = ALU_SLT; end
          F_SLL: begin regwrite = ENABLE; alu = ALU_SLL; end
          F_SRL: begin regwrite = ENABLE; alu = ALU_SRL; end
          F_JR:  jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin regwrite = ENABLE; alusrc = 1'b1; end
      OP_SLTI: begin regwrite = ENABLE; alusrc = 1'b1; alu = ALU_SLT; end
      OP_ANDI: begin regwrite = ENABLE; alusrc = 1'b1; zimm = 1'b1; alu = ALU_AND; end
      OP_ORI:  begin regwrite = ENABLE; alusrc = 1'b1; zimm = 1'b1; alu = ALU_OR; end
      OP_LUI:  begin regwrite = ENABLE; alusrc = 1'b1; zimm = 1'b1; alu = ALU_LUI; end
      OP_LW:   begin regwrite = ENABLE; alusrc = 1'b1; ld = 1'b1; end
      OP_LB:   begin regwrite = lb_op; alusrc = 1'b1; end
      OP_SW:   begin memwr = ENABLE; alusrc = 1'b1; end
      OP_BEQ:  branch = 1'b1;
      OP_BNE:  begin branch = 1'b1; bne = 1'b1; end
      OP_J:    jump = 1'b1;
      OP_JAL:  begin jump = 1'b1; link = 1'b1; regwrite = ENABLE; end
      default: ;
    endcase
  end
  mipse_rfile rfile_1 (.clk(clk), .rst_n(rst_n), .we(regwrite), .ra1(rs), .ra2(rt), .wa(wa),
                       .wd(result), .rd1(a), .rd2(rt_val));
  assign b = alusrc ? ext : rt_val;
  always_comb
    case (alu)
      ALU_SUB: bus.aluresult = a - b;
      ALU_AND: bus.aluresult = a & b;
      ALU_OR:  bus.aluresult = a | b;
      ALU_SLT: bus.aluresult = {31'h0, $signed(a) < $signed(b)};
      ALU_SLL: bus.aluresult = b << shamt;
      ALU_SRL: bus.aluresult = b >> shamt;
      ALU_LUI: bus.aluresult = b << 16;
      default: bus.aluresult = a + b;
    endcase
  assign lbv = {{24{bus.readdata[{bus.aluresult[1:0], 3'b000} + 7]}}, bus.readdata[{bus.aluresult[1:0], 3'b000} +: 8]};
  assign pc4 = bus.pc + 32'd4;
  assign result = link ? pc4 : ld ? bus.readdata : lb_op ? lbv : bus.aluresult;
  assign wa = link ? 5'd31 : regdst ? rd : rt;
  assign taken = branch && (bne ? a != rt_val : a == rt_val);
  assign pc_next = jr ? a : jump ? {pc4[31:28], bus.instr[25:0], 2'b00} :
                   taken ? pc4 + {ext[29:0], 2'b00} : pc4;
  assign bus.writedata = rt_val;
  assign bus.memwrite = memwr && !rst_n;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) bus.pc <= '0;
    else bus.pc <= pc_next;
endmodule

// File: tb/tb_mipse_cpu.sv
// tb_mipse_cpu: table-driven directed bench for mipse_cpu plus reset sequences
module tb_mipse_cpu;
  logic clk = 1'b0, rst_n = 1'b1;
  int tests = 0, fails = 0;
  mipse_if bus();
  mipse_cpu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] instr, rdata, ealu;
    logic calu, emw;
    logic [31:0] ewd;
    int ri;
    logic [31:0] ev, epc;
  } vec_t;
  vec_t v [25];
  function automatic logic [31:0] it(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
    return {op, s, t, imm};
  endfunction
  function automatic logic [31:0] rt(logic [4:0] s, logic [4:0] t, logic [4:0] d, logic [4:0] sh, logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction
  function automatic logic [31:0] jt(logic [5:0] op, logic [25:0] tg);
    return {op, tg};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    logic [31:0] lbe;
`ifdef MIPSE_LB_EN
    lbe = 32'hffffff80;
`else
    lbe = 32'h0;
`endif
    v[0]  = '{it(6'h08, 0, 1, 16'd5),      0, 32'd5,         1, 0, 0, 1,  32'd5,         32'h04};
    v[1]  = '{it(6'h08, 0, 2, 16'hfffd),   0, 32'hfffffffd,  1, 0, 0, 2,  32'hfffffffd,  32'h08};
    v[2]  = '{rt(1, 2, 3, 0, 6'h20),       0, 32'd2,         1, 0, 0, 3,  32'd2,         32'h0c};
    v[3]  = '{rt(2, 1, 4, 0, 6'h2a),       0, 32'd1,         1, 0, 0, 4,  32'd1,         32'h10};
    v[4]  = '{it(6'h04, 1, 1, 16'd2),      0, 0,             0, 0, 0, 1,  32'd5,         32'h1c};
    v[5]  = '{it(6'h05, 1, 1, 16'd2),      0, 0,             0, 0, 0, 1,  32'd5,         32'h20};
    v[6]  = '{jt(6'h03, 26'h40),           0, 0,             0, 0, 0, 31, 32'h24,        32'h100};
    v[7]  = '{rt(31, 0, 0, 0, 6'h08),      0, 0,             0, 0, 0, 31, 32'h24,        32'h24};
    v[8]  = '{it(6'h0f, 0, 5, 16'h1234),   0, 32'h12340000,  1, 0, 0, 5,  32'h12340000,  32'h28};
    v[9]  = '{it(6'h0d, 5, 5, 16'h5678),   0, 32'h12345678,  1, 0, 0, 5,  32'h12345678,  32'h2c};
    v[10] = '{it(6'h08, 0, 6, 16'h400),    0, 32'h400,       1, 0, 0, 6,  32'h400,       32'h30};
    v[11] = '{it(6'h2b, 6, 1, 16'd0),      0, 32'h400,       1, 1, 5, 7,  32'd0,         32'h34};
    v[12] = '{it(6'h23, 6, 7, 16'd0),      5, 32'h400,       1, 0, 0, 7,  32'd5,         32'h38};
    v[13] = '{it(6'h20, 6, 10, 16'd1),     32'h80ff, 32'h401, 1, 0, 0, 10, lbe,          32'h3c};
    v[14] = '{rt(0, 1, 11, 3, 6'h00),      0, 32'h28,        1, 0, 0, 11, 32'h28,        32'h40};
    v[15] = '{rt(0, 2, 12, 28, 6'h02),     0, 32'hf,         1, 0, 0, 12, 32'hf,         32'h44};
    v[16] = '{rt(1, 2, 13, 0, 6'h22),      0, 32'd8,         1, 0, 0, 13, 32'd8,         32'h48};
    v[17] = '{rt(1, 2, 14, 0, 6'h25),      0, 32'hfffffffd,  1, 0, 0, 14, 32'hfffffffd,  32'h4c};
    v[18] = '{rt(2, 1, 15, 0, 6'h24),      0, 32'd5,         1, 0, 0, 15, 32'd5,         32'h50};
    v[19] = '{it(6'h0c, 2, 16, 16'hff00),  0, 32'hff00,      1, 0, 0, 16, 32'hff00,      32'h54};
    v[20] = '{it(6'h0a, 2, 17, 16'd0),     0, 32'd1,         1, 0, 0, 17, 32'd1,         32'h58};
    v[21] = '{it(6'h3f, 1, 18, 16'hffff),  0, 0,             0, 0, 0, 18, 32'd0,         32'h5c};
    v[22] = '{it(6'h08, 1, 0, 16'd7),      0, 32'd12,        1, 0, 0, 0,  32'd0,         32'h60};
    v[23] = '{it(6'h08, 0, 8, 16'h7fff),   0, 32'h7fff,      1, 0, 0, 8,  32'h7fff,      32'h64};
    v[24] = '{it(6'h2b, 8, 1, 16'd0),      0, 32'h7fff,      1, 1, 5, 8,  32'h7fff,      32'h68};
    bus.instr = it(6'h2b, 0, 1, 16'h7fff);
    bus.readdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", bus.pc, 0);
    chk("reset memwrite", {31'h0, bus.memwrite}, 0);
    for (int r = 1; r < 32; r++) chk($sformatf("reset rf%0d", r), dut.rfile_1.rf[r], 0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b0;
      bus.instr = v[i].instr;
      bus.readdata = v[i].rdata;
      #1;
      if (v[i].calu) chk($sformatf("v%0d aluresult", i), bus.aluresult, v[i].ealu);
      chk($sformatf("v%0d memwrite", i), {31'h0, bus.memwrite}, {31'h0, v[i].emw});
      if (v[i].emw) chk($sformatf("v%0d writedata", i), bus.writedata, v[i].ewd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", i), bus.pc, v[i].epc);
      chk($sformatf("v%0d rf%0d", i, v[i].ri), dut.rfile_1.rf[v[i].ri], v[i].ev);
    end
    @(negedge clk);
    bus.instr = it(6'h08, 1, 1, 16'd1);
    #1;
    chk("old read aluresult", bus.aluresult, 32'd6);
    @(posedge clk);
    #1;
    chk("new value rf1", dut.rfile_1.rf[1], 32'd6);
    @(negedge clk);
    bus.instr = it(6'h2b, 8, 1, 16'd0);
    #1;
    chk("halt memwrite", {31'h0, bus.memwrite}, 1);
    chk("halt aluresult", bus.aluresult, 32'h7fff);
    #1 rst_n = 1'b1;
    #1;
    chk("midrun reset pc", bus.pc, 0);
    chk("midrun reset memwrite", {31'h0, bus.memwrite}, 0);
    chk("midrun reset rf1", dut.rfile_1.rf[1], 0);
    @(posedge clk);
    #1;
    chk("held reset pc", bus.pc, 0);
    chk("held reset rf8", dut.rfile_1.rf[8], 0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.instr = it(6'h08, 0, 1, 16'd5);
    @(posedge clk);
    #1;
    chk("restart pc", bus.pc, 32'h4);
    chk("restart rf1", dut.rfile_1.rf[1], 32'd5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
